// File: rtl/dvma_arbiter_if.sv
// Request/grant bundle between the CPU/DVMA/refresh requesters and the memory arbiter.
// The arbiter connects to the slave side and the requesters connect to the master side.
interface dvma_arbiter_if;
  logic cpu_req;
  logic dvma_req;
  logic refresh_req;
  logic aen;
  logic xen;
  logic c_s7;
  logic cpu_ack;
  logic ref_en;
  logic dvma_tmo;

  modport master (
    output cpu_req, dvma_req, refresh_req,
    input  aen, xen, c_s7, cpu_ack, ref_en, dvma_tmo
  );

  modport slave (
    input  cpu_req, dvma_req, refresh_req,
    output aen, xen, c_s7, cpu_ack, ref_en, dvma_tmo
  );
endinterface

// File: rtl/dvma_arbiter.sv
// Onboard-memory arbiter: CPU, DVMA and refresh share the memory datapath.
// All grants leave from IDLE, so every ownership change has a dead clock between owners.
module dvma_arbiter #(
  parameter int DVMA_WAIT = 7,
  parameter int REF_LEN   = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset,
  dvma_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU,
    S_DVMA_RUN,
    S_DVMA_ACK,
    S_REFRESH
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(DVMA_WAIT - 1);
  localparam logic [2:0] REF_LAST  = 3'(REF_LEN - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       pend_q, pend_d;
  logic       alt_q, alt_d;
  logic       lock_q, lock_d;
  logic       ready_q, ready_d;
  logic       aen_q, aen_d;
  logic       xen_q, xen_d;
  logic       c_s7_q, c_s7_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       ref_en_q, ref_en_d;
  logic       dvma_tmo_q, dvma_tmo_d;
  logic       enter_ref;
  logic       tmo_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    alt_d     = alt_q;
    enter_ref = 1'b0;
    tmo_hit   = 1'b0;
    // Holds off grants on the first edge after reset release.
    ready_d   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (ready_q) begin
          if (pend_q) begin
            state_d   = S_REFRESH;
            cnt_d     = 3'd0;
            enter_ref = 1'b1;
          end else if (bus.cpu_req && alt_q) begin
            // Last grant was DVMA: a waiting CPU goes next.
            state_d = S_CPU;
            alt_d   = 1'b0;
          end else if (bus.dvma_req && !lock_q) begin
            state_d = S_DVMA_RUN;
            cnt_d   = 3'd0;
            alt_d   = 1'b1;
          end else if (bus.cpu_req) begin
            state_d = S_CPU;
            alt_d   = 1'b0;
          end
        end
      end

      S_CPU: begin
        if (!bus.cpu_req) state_d = S_IDLE;
      end

      S_DVMA_RUN: begin
        if (!bus.dvma_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = S_DVMA_ACK;
          tmo_cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_DVMA_ACK: begin
        if (!bus.dvma_req) begin
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      S_REFRESH: begin
        if (cnt_q == REF_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 3'd1;
      end

      default: state_d = S_IDLE;
    endcase

    // A pulse landing on the refresh entry clock survives for the next slot.
    pend_d = bus.refresh_req | (pend_q & ~enter_ref);
    // After a timeout the stuck requester must be seen low before it can win again.
    lock_d = tmo_hit | (lock_q & bus.dvma_req);

    aen_d      = (state_d == S_CPU);
    cpu_ack_d  = (state_q == S_CPU) && (state_d == S_CPU);
    xen_d      = (state_d == S_DVMA_RUN) || (state_d == S_DVMA_ACK);
    c_s7_d     = (state_d == S_DVMA_ACK);
    ref_en_d   = (state_d == S_REFRESH);
    dvma_tmo_d = tmo_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      tmo_cnt_q  <= 8'd0;
      pend_q     <= 1'b0;
      alt_q      <= 1'b0;
      lock_q     <= 1'b0;
      ready_q    <= 1'b0;
      aen_q      <= 1'b0;
      xen_q      <= 1'b0;
      c_s7_q     <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ref_en_q   <= 1'b0;
      dvma_tmo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pend_q     <= pend_d;
      alt_q      <= alt_d;
      lock_q     <= lock_d;
      ready_q    <= ready_d;
      aen_q      <= aen_d;
      xen_q      <= xen_d;
      c_s7_q     <= c_s7_d;
      cpu_ack_q  <= cpu_ack_d;
      ref_en_q   <= ref_en_d;
      dvma_tmo_q <= dvma_tmo_d;
    end
  end

  assign bus.aen      = aen_q;
  assign bus.xen      = xen_q;
  assign bus.c_s7     = c_s7_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.ref_en   = ref_en_q;
  assign bus.dvma_tmo = dvma_tmo_q;

endmodule

// File: tb/tb_dvma_arbiter.sv
// Bench for dvma_arbiter: directed scenario tasks plus a randomized run against an
// ownership/age reference model.
module tb_dvma_arbiter;
  localparam int W   = 7;
  localparam int RL  = 4;
  localparam int TMO = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  dvma_arbiter_if bus();

  dvma_arbiter #(.DVMA_WAIT(W), .REF_LEN(RL), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  wire [5:0] dut_o = {bus.aen, bus.cpu_ack, bus.xen, bus.c_s7, bus.ref_en, bus.dvma_tmo};

  // Reference model: owner (0 none, 1 cpu, 2 dvma, 3 refresh) and clocks since grant.
  int m_own = 0, m_age = 0;
  bit m_pend = 0, m_alt = 0, m_lock = 0, m_ready = 0, m_tmo = 0;
  bit p_old, l_old, m_entref;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own = 0; m_age = 0; m_pend = 0; m_alt = 0; m_lock = 0; m_ready = 0; m_tmo = 0;
    end else begin
      p_old = m_pend; l_old = m_lock; m_tmo = 0; m_entref = 0;
      case (m_own)
        0: if (m_ready) begin
          if (p_old) begin m_own = 3; m_age = 0; m_entref = 1; end
          else if (bus.cpu_req && m_alt) begin m_own = 1; m_age = 0; m_alt = 0; end
          else if (bus.dvma_req && !l_old) begin m_own = 2; m_age = 0; m_alt = 1; end
          else if (bus.cpu_req) begin m_own = 1; m_age = 0; m_alt = 0; end
        end
        1: if (!bus.cpu_req) m_own = 0; else m_age++;
        2: if (!bus.dvma_req) m_own = 0;
           else if (m_age == W + TMO - 1) begin m_own = 0; m_tmo = 1; m_lock = 1; end
           else m_age++;
        default: if (m_age == RL - 1) m_own = 0; else m_age++;
      endcase
      m_pend = bus.refresh_req || (p_old && !m_entref);
      if (!bus.dvma_req) m_lock = 0;
      m_ready = 1;
    end
  end

  function automatic logic [5:0] model_out();
    return {m_own == 1, m_own == 1 && m_age >= 1, m_own == 2, m_own == 2 && m_age >= W,
            m_own == 3, m_tmo};
  endfunction

  task automatic apply_reset();
    bus.cpu_req = 0; bus.dvma_req = 0; bus.refresh_req = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); @(negedge clk); reset = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cpu_req = 1; bus.dvma_req = 0; bus.refresh_req = 0;
    #1 reset = 1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (dut_o !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 000000", dut_o); end
    reset = 0;
    @(negedge clk);
    n_tests++;
    if (bus.aen !== 1'b0) begin n_fail++; $display("FAIL first_edge_no_grant: aen got %b expected 0", bus.aen); end
    @(negedge clk);
    n_tests++;
    if (bus.aen !== 1'b1) begin n_fail++; $display("FAIL second_edge_grant: aen got %b expected 1", bus.aen); end
    bus.cpu_req = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_cpu();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.aen !== (i >= 1 && i <= 6)) begin
        n_fail++; $display("FAIL cpu_aen cyc %0d: got %b expected %b", i, bus.aen, (i >= 1 && i <= 6));
      end
      n_tests++;
      if (bus.cpu_ack !== (i >= 2 && i <= 6)) begin
        n_fail++; $display("FAIL cpu_ack cyc %0d: got %b expected %b", i, bus.cpu_ack, (i >= 2 && i <= 6));
      end
      bus.cpu_req = (i < 6);
    end
  endtask

  task automatic test_dvma();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.xen !== (i >= 1 && i <= 12)) begin
        n_fail++; $display("FAIL dvma_xen cyc %0d: got %b expected %b", i, bus.xen, (i >= 1 && i <= 12));
      end
      n_tests++;
      if (bus.c_s7 !== (i >= 1 + W && i <= 12)) begin
        n_fail++; $display("FAIL dvma_c_s7 cyc %0d: got %b expected %b", i, bus.c_s7, (i >= 1 + W && i <= 12));
      end
      bus.dvma_req = (i < 12);
    end
  endtask

  task automatic test_contention();
    int seq[$];
    int exp_seq[6] = '{0, 2, 0, 1, 0, 2};
    int cur, last;
    apply_reset();
    last = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.aen && bus.xen) begin n_fail++; $display("FAIL contention_overlap cyc %0d: aen and xen both 1", i); end
      cur = bus.aen ? 1 : (bus.xen ? 2 : 0);
      if (cur != last) seq.push_back(cur);
      last = cur;
      bus.dvma_req = !bus.c_s7;
      bus.cpu_req  = !bus.cpu_ack;
    end
    bus.dvma_req = 0; bus.cpu_req = 0;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (k >= seq.size()) begin
        n_fail++; $display("FAIL contention_order step %0d: got none expected %0d", k, exp_seq[k]);
      end else if (seq[k] != exp_seq[k]) begin
        n_fail++; $display("FAIL contention_order step %0d: got %0d expected %0d", k, seq[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_refresh();
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.ref_en !== (i >= 12 && i <= 15)) begin
        n_fail++; $display("FAIL refresh_ref_en cyc %0d: got %b expected %b", i, bus.ref_en, (i >= 12 && i <= 15));
      end
      bus.dvma_req    = (i < 10);
      bus.refresh_req = (i == 3 || i == 5);
    end
  endtask

  task automatic test_timeout();
    int c7 = 0, tmo_n = 0, tmo_at = -1;
    apply_reset();
    for (int i = 0; i < 276; i++) begin
      @(negedge clk);
      if (bus.c_s7) c7++;
      if (bus.dvma_tmo) begin tmo_n++; tmo_at = i; end
      if (i >= 263 && i <= 272) begin
        n_tests++;
        if (bus.xen !== (i >= 272)) begin
          n_fail++; $display("FAIL timeout_xen cyc %0d: got %b expected %b", i, bus.xen, (i >= 272));
        end
      end
      bus.dvma_req = (i != 270);
    end
    bus.dvma_req = 0;
    n_tests++;
    if (c7 != TMO) begin n_fail++; $display("FAIL timeout_c_s7_len: got %0d expected %0d", c7, TMO); end
    n_tests++;
    if (tmo_n != 1 || tmo_at != 263) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d pulses at %0d expected 1 at 263", tmo_n, tmo_at);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.dvma_req = 1;
    for (int k = 0; k < 20 && !bus.c_s7; k++) @(negedge clk);
    n_tests++;
    if (bus.c_s7 !== 1'b1) begin n_fail++; $display("FAIL areset_reach_ack: c_s7 got %b expected 1", bus.c_s7); end
    bus.cpu_req = 1;
    @(posedge clk); #2 reset = 1; #1;
    n_tests++;
    if (dut_o !== 6'b0) begin n_fail++; $display("FAIL areset_immediate: got %b expected 000000", dut_o); end
    @(negedge clk); bus.dvma_req = 0; reset = 0;
    @(negedge clk);
    n_tests++;
    if (bus.aen !== 1'b0) begin n_fail++; $display("FAIL areset_no_early_grant: aen got %b expected 0", bus.aen); end
    @(negedge clk);
    n_tests++;
    if (bus.aen !== 1'b1) begin n_fail++; $display("FAIL areset_cpu_grant: aen got %b expected 1", bus.aen); end
    @(negedge clk);
    n_tests++;
    if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL areset_cpu_ack: got %b expected 1", bus.cpu_ack); end
    bus.cpu_req = 0;
  endtask

  task automatic test_random();
    logic [5:0] exp_o;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      exp_o = model_out();
      n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL random_outputs cyc %0d: got %b expected %b", i, dut_o, exp_o);
      end
      n_tests++;
      if ((32'(bus.aen) + 32'(bus.xen) + 32'(bus.ref_en)) > 1) begin
        n_fail++; $display("FAIL random_exclusive cyc %0d: grants %b", i, {bus.aen, bus.xen, bus.ref_en});
      end
      if ($urandom_range(0, 7) == 0) bus.cpu_req  = !bus.cpu_req;
      if ($urandom_range(0, 7) == 0) bus.dvma_req = !bus.dvma_req;
      bus.refresh_req = ($urandom_range(0, 19) == 0);
    end
    bus.cpu_req = 0; bus.dvma_req = 0; bus.refresh_req = 0;
  endtask

  initial begin
    test_reset();
    test_cpu();
    test_dvma();
    test_contention();
    test_refresh();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
